// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller: streams operands LSB-first through an external
// 1-bit full adder and reassembles the sum, feeding the adder's carry-out back as carry-in.
module serial_adder_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] OPA,
  input  logic [N-1:0] OPB,
  input  logic         CIN,
  output logic         FA_A,
  output logic         FA_B,
  output logic         FA_CI,
  input  logic         FA_S,
  input  logic         FA_CO,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  logic [N-1:0]  res;
  logic          carry;
  logic [CW-1:0] cnt;

  // Full-adder operands are only presented while a bit slice is being processed.
  assign FA_A  = (state == S_RUN) & sh_a[0];
  assign FA_B  = (state == S_RUN) & sh_b[0];
  assign FA_CI = (state == S_RUN) & carry;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            sh_a  <= OPA;
            sh_b  <= OPB;
            carry <= CIN;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res   <= {FA_S, res[N-1:1]};
          carry <= FA_CO;
          cnt   <= cnt + CW'(1);
          // Last bit: publish the result including the bit produced on this edge.
          if (cnt == LAST) begin
            SUM   <= {FA_S, res[N-1:1]};
            COUT  <= FA_CO;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: behavioural full adder plus arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned N = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [N-1:0] OPA;
  logic [N-1:0] OPB;
  logic         CIN;
  logic         FA_A;
  logic         FA_B;
  logic         FA_CI;
  logic         FA_S;
  logic         FA_CO;
  logic [N-1:0] SUM;
  logic         COUT;
  logic         BUSY;
  logic         DONE;

  int vectors;
  int miscompares;

  serial_adder_ctrl #(.N(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .FA_A(FA_A), .FA_B(FA_B), .FA_CI(FA_CI), .FA_S(FA_S), .FA_CO(FA_CO),
    .SUM(SUM), .COUT(COUT), .BUSY(BUSY), .DONE(DONE)
  );

  // External 1-bit full adder
  assign FA_S  = FA_A ^ FA_B ^ FA_CI;
  assign FA_CO = (FA_A & FA_B) | (FA_CI & (FA_A ^ FA_B));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Carry into bit position i of a + b + c, from plain integer arithmetic.
  function automatic logic carry_into(input int unsigned a, input int unsigned b,
                                      input int unsigned c, input int unsigned i);
    int unsigned m;
    m = (32'd1 << i) - 32'd1;
    return 1'(((a & m) + (b & m) + c) >> i);
  endfunction

  // One addition from IDLE; optionally pulses START with OPA=1 at the given RUN cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input int inject_cycle, input string tag);
    int unsigned total;
    logic [N-1:0] exp_sum;
    logic exp_cout;
    total    = int'(a) + int'(b) + int'(c);
    exp_sum  = N'(total);
    exp_cout = 1'(total >> N);
    START = 1'b1; OPA = a; OPB = b; CIN = c;
    step();
    START = 1'b0; OPA = $urandom; OPB = $urandom; CIN = 1'($urandom);
    for (int i = 0; i < int'(N); i++) begin
      vectors++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        miscompares++;
        $display("FAIL %s run%0d busy/done: got %b/%b want 1/0", tag, i, BUSY, DONE);
      end
      vectors++;
      if (FA_A !== a[i] || FA_B !== b[i] ||
          FA_CI !== carry_into(int'(a), int'(b), int'(c), i)) begin
        miscompares++;
        $display("FAIL %s fa_in%0d: got a=%b b=%b ci=%b want a=%b b=%b ci=%b", tag, i,
                 FA_A, FA_B, FA_CI, a[i], b[i], carry_into(int'(a), int'(b), int'(c), i));
      end
      if (i + 1 == inject_cycle) begin
        START = 1'b1; OPA = N'(1);
      end else begin
        START = 1'b0;
      end
      step();
    end
    START = 1'b0;
    vectors++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || SUM !== exp_sum || COUT !== exp_cout) begin
      miscompares++;
      $display("FAIL %s result: got done=%b busy=%b sum=%h cout=%b want 1 0 %h %b",
               tag, DONE, BUSY, SUM, COUT, exp_sum, exp_cout);
    end
    vectors++;
    if (FA_A !== 1'b0 || FA_B !== 1'b0 || FA_CI !== 1'b0) begin
      miscompares++;
      $display("FAIL %s fa_done: got %b%b%b want 000", tag, FA_A, FA_B, FA_CI);
    end
    step();
    vectors++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || SUM !== exp_sum || COUT !== exp_cout) begin
      miscompares++;
      $display("FAIL %s hold: got done=%b busy=%b sum=%h cout=%b want 0 0 %h %b",
               tag, DONE, BUSY, SUM, COUT, exp_sum, exp_cout);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; OPA = '0; OPB = '0; CIN = 1'b0;
    step(); step();
    vectors++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || SUM !== '0 || COUT !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outs: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               BUSY, DONE, SUM, COUT);
    end
    RST_N = 1'b1;
    step(); step();
    vectors++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || FA_A !== 1'b0 || FA_B !== 1'b0 || FA_CI !== 1'b0) begin
      miscompares++;
      $display("FAIL idle no start: got busy=%b done=%b fa=%b%b%b want 0 0 000",
               BUSY, DONE, FA_A, FA_B, FA_CI);
    end
  endtask

  task automatic test_directed();
    run_op(8'h0F, 8'h01, 1'b0, 0, "case1");
    run_op(8'hFF, 8'h01, 1'b0, 0, "ripple");
    run_op(8'hAA, 8'h55, 1'b1, 0, "alt_cin");
    run_op(8'h00, 8'h00, 1'b0, 0, "zero");
  endtask

  task automatic test_start_ignored();
    run_op(8'h0F, 8'h01, 1'b0, 3, "ign_start");
    for (int i = 0; i < int'(N) + 3; i++) begin
      vectors++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || SUM !== 8'h10) begin
        miscompares++;
        $display("FAIL ign_start extra%0d: got done=%b busy=%b sum=%h want 0 0 10",
                 i, DONE, BUSY, SUM);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    START = 1'b1; OPA = 8'hFF; OPB = 8'h01; CIN = 1'b0;
    step();
    START = 1'b0;
    step(); step(); step();
    RST_N = 1'b0;
    step();
    vectors++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || SUM !== '0 || COUT !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               BUSY, DONE, SUM, COUT);
    end
    RST_N = 1'b1;
    for (int i = 0; i < int'(N) + 2; i++) begin
      step();
      vectors++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_rst idle%0d: got done=%b busy=%b want 0 0", i, DONE, BUSY);
      end
    end
    run_op(8'h3C, 8'h4B, 1'b1, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b;
    logic c;
    int unsigned total;
    START = 1'b1;
    for (int op = 0; op < 200; op++) begin
      a = N'($urandom); b = N'($urandom); c = 1'($urandom);
      total = int'(a) + int'(b) + int'(c);
      OPA = a; OPB = b; CIN = c;
      step();
      for (int j = 1; j <= int'(N) + 1; j++) begin
        vectors++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b op%0d cyc%0d: got busy=%b done=%b want 1 0", op, j, BUSY, DONE);
        end
        OPA = N'($urandom); OPB = N'($urandom); CIN = 1'($urandom);
        step();
        if (j == int'(N)) begin
          vectors++;
          if (DONE !== 1'b1 || BUSY !== 1'b0 || {COUT, SUM} !== (N+1)'(total)) begin
            miscompares++;
            $display("FAIL b2b op%0d result: got done=%b busy=%b {cout,sum}=%h want 1 0 %h",
                     op, DONE, BUSY, {COUT, SUM}, (N+1)'(total));
          end
          OPA = N'($urandom); OPB = N'($urandom);
          step();
          break;
        end
      end
      vectors++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b op%0d idle: got busy=%b done=%b want 0 0", op, BUSY, DONE);
      end
    end
    START = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
